// File: rtl/wb_commit_stage.sv
// wb_commit_stage: writeback/commit stage that registers one instruction per cycle,
// extracts load data, drives the regfile write port and commit/difftest signals.
// Ports: clk/rst (sync active-high); i_valid/o_ready handshake from MEM;
// i_pc, i_inst, i_rd, i_rd_wen, i_alu_res, i_mem_addr, i_mem_rdata instruction payload;
// o_rd/o_rd_wen/o_rd_wdata regfile write; o_pc/o_inst/o_cmtvalid/o_skipcmt commit;
// o_instret committed count; o_halted halt instruction has committed.
module wb_commit_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [63:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic [4:0]  i_rd,
    input  logic        i_rd_wen,
    input  logic [63:0] i_alu_res,
    input  logic [63:0] i_mem_addr,
    input  logic [63:0] i_mem_rdata,
    output logic [4:0]  o_rd,
    output logic        o_rd_wen,
    output logic [63:0] o_rd_wdata,
    output logic [63:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_cmtvalid,
    output logic        o_skipcmt,
    output logic [63:0] o_instret,
    output logic        o_halted
);
    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;
    logic [0:0]  state_q, state_d;
    logic [63:0] pc_q, pc_d, rd_wdata_q, rd_wdata_d, instret_q, instret_d;
    logic [31:0] inst_q, inst_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_wen_q, rd_wen_d, cmtvalid_q, cmtvalid_d, skipcmt_q, skipcmt_d;
    logic        accept, is_load, is_mem, is_ctr_csr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [63:0] shifted, load_data;
    logic        unused_bits;
    assign unused_bits = ^{i_mem_addr[63:32], i_mem_addr[30:3], i_inst[19:15], i_inst[11:7]};
    always_comb begin
        opcode     = i_inst[6:0];
        funct3     = i_inst[14:12];
        accept     = i_valid && o_ready;
        is_load    = opcode == 7'h03;
        is_mem     = is_load || opcode == 7'h23;
        // cycle/mcycle reads differ from the reference model, so difftest skips them
        is_ctr_csr = opcode == 7'h73 && funct3 != 3'd0 &&
                     (i_inst[31:20] == 12'hB00 || i_inst[31:20] == 12'hC00);
        // move the addressed byte to bit 0; bytes past the doubleword read as zero
        shifted    = i_mem_rdata >> {i_mem_addr[2:0], 3'b000};
        case (funct3)
            3'd0:    load_data = {{56{shifted[7]}}, shifted[7:0]};
            3'd1:    load_data = {{48{shifted[15]}}, shifted[15:0]};
            3'd2:    load_data = {{32{shifted[31]}}, shifted[31:0]};
            3'd3:    load_data = shifted;
            3'd4:    load_data = {56'd0, shifted[7:0]};
            3'd5:    load_data = {48'd0, shifted[15:0]};
            3'd6:    load_data = {32'd0, shifted[31:0]};
            default: load_data = 64'd0;
        endcase
        state_d    = (accept && opcode == 7'h6b) ? HALTED : state_q;
        pc_d       = accept ? i_pc : pc_q;
        inst_d     = accept ? i_inst : inst_q;
        rd_d       = accept ? i_rd : rd_q;
        rd_wdata_d = accept ? (is_load ? load_data : i_alu_res) : rd_wdata_q;
        rd_wen_d   = accept && i_rd_wen && i_rd != 5'd0;
        cmtvalid_d = accept;
        skipcmt_d  = accept && ((is_mem && !i_mem_addr[31]) || is_ctr_csr);
        instret_d  = instret_q + {63'd0, accept};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= '0;
            inst_q     <= '0;
            rd_q       <= '0;
            rd_wdata_q <= '0;
            rd_wen_q   <= 1'b0;
            cmtvalid_q <= 1'b0;
            skipcmt_q  <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            rd_q       <= rd_d;
            rd_wdata_q <= rd_wdata_d;
            rd_wen_q   <= rd_wen_d;
            cmtvalid_q <= cmtvalid_d;
            skipcmt_q  <= skipcmt_d;
            instret_q  <= instret_d;
        end
    end
    assign o_ready    = state_q == RUN;
    assign o_halted   = state_q == HALTED;
    assign o_pc       = pc_q;
    assign o_inst     = inst_q;
    assign o_rd       = rd_q;
    assign o_rd_wen   = rd_wen_q;
    assign o_rd_wdata = rd_wdata_q;
    assign o_cmtvalid = cmtvalid_q;
    assign o_skipcmt  = skipcmt_q;
    assign o_instret  = instret_q;
endmodule

// File: tb/tb_wb_commit_stage.sv
// tb_wb_commit_stage: randomized and directed checks of wb_commit_stage against a behavioural model.
module tb_wb_commit_stage;
    logic        clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_rd_wen = 1'b0;
    logic [63:0] i_pc = '0, i_alu_res = '0, i_mem_addr = '0, i_mem_rdata = '0;
    logic [31:0] i_inst = '0;
    logic [4:0]  i_rd = '0;
    logic        o_ready, o_rd_wen, o_cmtvalid, o_skipcmt, o_halted;
    logic [4:0]  o_rd;
    logic [63:0] o_rd_wdata, o_pc, o_instret;
    logic [31:0] o_inst;
    int errs = 0, checks = 0;
    logic        m_halted = 0, m_cmt = 0, m_wen = 0, m_skip = 0;
    logic [63:0] m_instret = 0, m_pc = 0, m_wdata = 0;
    logic [31:0] m_inst = 0;
    logic [4:0]  m_rd = 0;

    wb_commit_stage dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc), .i_inst(i_inst),
        .i_rd(i_rd), .i_rd_wen(i_rd_wen), .i_alu_res(i_alu_res), .i_mem_addr(i_mem_addr),
        .i_mem_rdata(i_mem_rdata), .o_rd(o_rd), .o_rd_wen(o_rd_wen), .o_rd_wdata(o_rd_wdata),
        .o_pc(o_pc), .o_inst(o_inst), .o_cmtvalid(o_cmtvalid), .o_skipcmt(o_skipcmt),
        .o_instret(o_instret), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [63:0] rdata, input logic [2:0] f3);
        int n;
        int off;
        logic [63:0] v;
        if (f3 == 3'd7) return 64'd0;
        n = 1 << f3[1:0];
        off = int'(addr[2:0]);
        v = '0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (f3 < 3'd4 && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    function automatic logic ref_skip(input logic [31:0] inst, input logic [63:0] addr);
        logic [6:0] op;
        op = inst[6:0];
        if ((op == 7'h03 || op == 7'h23) && !addr[31]) return 1'b1;
        return op == 7'h73 && inst[14:12] != 3'd0 && (inst[31:20] == 12'hB00 || inst[31:20] == 12'hC00);
    endfunction

    // applies one cycle of inputs, then advances the model to what the outputs should show
    task automatic drive(input logic r, input logic v, input logic [63:0] pc, input logic [31:0] inst,
                         input logic [4:0] rd, input logic wen, input logic [63:0] alu,
                         input logic [63:0] addr, input logic [63:0] rdata);
        rst = r; i_valid = v; i_pc = pc; i_inst = inst; i_rd = rd; i_rd_wen = wen;
        i_alu_res = alu; i_mem_addr = addr; i_mem_rdata = rdata;
        @(posedge clk);
        #1;
        if (r) begin
            m_halted = 0; m_cmt = 0; m_wen = 0; m_skip = 0; m_instret = 0;
            m_pc = 0; m_wdata = 0; m_inst = 0; m_rd = 0;
        end else if (v && !m_halted) begin
            m_cmt = 1; m_pc = pc; m_inst = inst; m_rd = rd;
            m_wen = wen && rd != 0;
            m_wdata = inst[6:0] == 7'h03 ? ref_load(addr, rdata, inst[14:12]) : alu;
            m_skip = ref_skip(inst, addr);
            m_instret = m_instret + 1;
            if (inst[6:0] == 7'h6b) m_halted = 1;
        end else begin
            m_cmt = 0; m_wen = 0; m_skip = 0;
        end
    endtask

    task automatic idle(input logic r);
        drive(r, 1'b0, 64'h0, 32'h0, 5'd0, 1'b0, 64'h0, 64'h0, 64'h0);
    endtask

    task automatic test_reset;
        idle(1'b1);
        checks++; if ({o_rd, o_rd_wen, o_rd_wdata, o_pc, o_inst, o_cmtvalid, o_skipcmt, o_instret, o_halted} !== '0) begin
            errs++; $display("FAIL reset_outputs got rd=%h wen=%b wdata=%h pc=%h inst=%h cmt=%b skip=%b instret=%h halted=%b exp all zero",
                             o_rd, o_rd_wen, o_rd_wdata, o_pc, o_inst, o_cmtvalid, o_skipcmt, o_instret, o_halted); end
        checks++; if (o_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    endtask

    task automatic test_addi;
        drive(1'b0, 1'b1, 64'h8000_0000, 32'h02A0_0293, 5'd5, 1'b1, 64'h2A, 64'h0, 64'h0);
        checks++; if (o_cmtvalid !== 1'b1) begin errs++; $display("FAIL addi_cmt got=%b exp=1", o_cmtvalid); end
        checks++; if (o_rd !== 5'd5) begin errs++; $display("FAIL addi_rd got=%0d exp=5", o_rd); end
        checks++; if (o_rd_wen !== 1'b1) begin errs++; $display("FAIL addi_wen got=%b exp=1", o_rd_wen); end
        checks++; if (o_rd_wdata !== 64'h2A) begin errs++; $display("FAIL addi_wdata got=%h exp=2a", o_rd_wdata); end
        checks++; if (o_instret !== 64'd1) begin errs++; $display("FAIL addi_instret got=%0d exp=1", o_instret); end
        checks++; if (o_pc !== 64'h8000_0000 || o_inst !== 32'h02A0_0293) begin errs++; $display("FAIL addi_pc_inst got=%h/%h exp=80000000/02a00293", o_pc, o_inst); end
        idle(1'b0);
        checks++; if (o_cmtvalid !== 1'b0 || o_rd_wen !== 1'b0) begin errs++; $display("FAIL idle_strobe got cmt=%b wen=%b exp=0/0", o_cmtvalid, o_rd_wen); end
        checks++; if (o_rd !== 5'd5 || o_rd_wdata !== 64'h2A || o_pc !== 64'h8000_0000) begin errs++; $display("FAIL idle_hold got rd=%0d wdata=%h pc=%h exp=5/2a/80000000", o_rd, o_rd_wdata, o_pc); end
    endtask

    task automatic test_load;
        drive(1'b0, 1'b1, 64'h100, 32'h0000_8083, 5'd1, 1'b1, 64'h0, 64'h8000_0003, 64'h0000_0000_8000_0000);
        checks++; if (o_rd_wdata !== 64'hFFFF_FFFF_FFFF_FF80) begin errs++; $display("FAIL lb_wdata got=%h exp=ffffffffffffff80", o_rd_wdata); end
        checks++; if (o_skipcmt !== 1'b0) begin errs++; $display("FAIL lb_skip got=%b exp=0", o_skipcmt); end
        drive(1'b0, 1'b1, 64'h104, 32'h0000_C083, 5'd1, 1'b1, 64'h0, 64'h8000_0003, 64'h0000_0000_8000_0000);
        checks++; if (o_rd_wdata !== 64'h80) begin errs++; $display("FAIL lbu_wdata got=%h exp=80", o_rd_wdata); end
        drive(1'b0, 1'b1, 64'h108, 32'h0000_9083, 5'd1, 1'b1, 64'h0, 64'h8000_0006, 64'h8234_5678_9ABC_DEF0);
        checks++; if (o_rd_wdata !== 64'hFFFF_FFFF_FFFF_8234) begin errs++; $display("FAIL lh_wdata got=%h exp=ffffffffffff8234", o_rd_wdata); end
        drive(1'b0, 1'b1, 64'h10C, 32'h0000_F083, 5'd1, 1'b1, 64'h55, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (o_rd_wdata !== 64'h0) begin errs++; $display("FAIL f3_7_wdata got=%h exp=0", o_rd_wdata); end
    endtask

    task automatic test_skip;
        drive(1'b0, 1'b1, 64'h200, 32'h0000_A023, 5'd0, 1'b0, 64'h0, 64'h0200_4000, 64'h0);
        checks++; if (o_skipcmt !== 1'b1 || o_rd_wen !== 1'b0) begin errs++; $display("FAIL sw_skip got skip=%b wen=%b exp=1/0", o_skipcmt, o_rd_wen); end
        drive(1'b0, 1'b1, 64'h204, 32'hB000_21F3, 5'd3, 1'b1, 64'h1234, 64'h0, 64'h0);
        checks++; if (o_skipcmt !== 1'b1 || o_rd_wdata !== 64'h1234) begin errs++; $display("FAIL mcycle_skip got skip=%b wdata=%h exp=1/1234", o_skipcmt, o_rd_wdata); end
        drive(1'b0, 1'b1, 64'h208, 32'h3000_21F3, 5'd3, 1'b1, 64'h0, 64'h0, 64'h0);
        checks++; if (o_skipcmt !== 1'b0) begin errs++; $display("FAIL mstatus_skip got=%b exp=0", o_skipcmt); end
        idle(1'b0);
        checks++; if (o_skipcmt !== 1'b0) begin errs++; $display("FAIL idle_skip got=%b exp=0", o_skipcmt); end
    endtask

    task automatic test_rd0;
        drive(1'b0, 1'b1, 64'h300, 32'h0000_0013, 5'd0, 1'b1, 64'h7, 64'h0, 64'h0);
        checks++; if (o_rd_wen !== 1'b0 || o_cmtvalid !== 1'b1) begin errs++; $display("FAIL rd0 got wen=%b cmt=%b exp=0/1", o_rd_wen, o_cmtvalid); end
    endtask

    task automatic test_back_to_back;
        idle(1'b1);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b1, 64'h400 + 64'(4*i), 32'h0000_0013, 5'(i), 1'b1, 64'(i), 64'h0, 64'h0);
            checks++; if (o_cmtvalid !== 1'b1 || o_instret !== 64'(i)) begin errs++; $display("FAIL b2b_%0d got cmt=%b instret=%0d exp=1/%0d", i, o_cmtvalid, o_instret, i); end
        end
        idle(1'b0);
        checks++; if (o_cmtvalid !== 1'b0 || o_instret !== 64'd3) begin errs++; $display("FAIL b2b_idle got cmt=%b instret=%0d exp=0/3", o_cmtvalid, o_instret); end
        drive(1'b1, 1'b1, 64'h500, 32'h0000_0013, 5'd4, 1'b1, 64'h9, 64'h0, 64'h0);
        checks++; if (o_cmtvalid !== 1'b0 || o_instret !== 64'd0) begin errs++; $display("FAIL b2b_rst got cmt=%b instret=%0d exp=0/0", o_cmtvalid, o_instret); end
    endtask

    task automatic test_halt;
        idle(1'b1);
        test_addi;
        drive(1'b0, 1'b1, 64'h600, 32'h0000_006B, 5'd0, 1'b0, 64'h0, 64'h0, 64'h0);
        checks++; if (o_cmtvalid !== 1'b1 || o_halted !== 1'b1 || o_ready !== 1'b0) begin errs++; $display("FAIL halt got cmt=%b halted=%b ready=%b exp=1/1/0", o_cmtvalid, o_halted, o_ready); end
        checks++; if (o_instret !== 64'd2) begin errs++; $display("FAIL halt_instret got=%0d exp=2", o_instret); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 64'h700, 32'h0000_0293, 5'd5, 1'b1, 64'h3, 64'h0, 64'h0);
            checks++; if (o_cmtvalid !== 1'b0 || o_instret !== 64'd2 || o_rd_wen !== 1'b0) begin errs++; $display("FAIL halted_ignore got cmt=%b instret=%0d wen=%b exp=0/2/0", o_cmtvalid, o_instret, o_rd_wen); end
        end
        idle(1'b1);
        checks++; if (o_halted !== 1'b0 || o_ready !== 1'b1) begin errs++; $display("FAIL halt_rst got halted=%b ready=%b exp=0/1", o_halted, o_ready); end
    endtask

    task automatic test_random;
        logic [6:0] ops [5] = '{7'h03, 7'h23, 7'h13, 7'h73, 7'h33};
        logic [11:0] csrs [4] = '{12'hB00, 12'hC00, 12'h300, 12'h341};
        logic [31:0] inst;
        logic [63:0] addr;
        idle(1'b1);
        for (int n = 0; n < 300; n++) begin
            inst = $urandom;
            inst[6:0] = ops[$urandom_range(0, 4)];
            if ($urandom_range(0, 1) == 1) inst[31:20] = csrs[$urandom_range(0, 3)];
            addr = {$urandom, $urandom};
            drive($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, {$urandom, $urandom}, inst,
                  5'($urandom), 1'($urandom), {$urandom, $urandom}, addr, {$urandom, $urandom});
            checks++; if ({o_cmtvalid, o_rd_wen, o_skipcmt, o_halted, o_ready} !== {m_cmt, m_wen, m_skip, m_halted, ~m_halted}) begin
                errs++; $display("FAIL rnd_flags cyc=%0d got cmt/wen/skip/halt/rdy=%b%b%b%b%b exp=%b%b%b%b%b", n,
                                 o_cmtvalid, o_rd_wen, o_skipcmt, o_halted, o_ready, m_cmt, m_wen, m_skip, m_halted, ~m_halted); end
            checks++; if (o_rd_wdata !== m_wdata || o_rd !== m_rd) begin errs++; $display("FAIL rnd_wb cyc=%0d inst=%h got rd=%0d wdata=%h exp rd=%0d wdata=%h", n, m_inst, o_rd, o_rd_wdata, m_rd, m_wdata); end
            checks++; if (o_pc !== m_pc || o_inst !== m_inst || o_instret !== m_instret) begin errs++; $display("FAIL rnd_commit cyc=%0d got pc=%h inst=%h instret=%0d exp pc=%h inst=%h instret=%0d", n, o_pc, o_inst, o_instret, m_pc, m_inst, m_instret); end
        end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_load;
        test_skip;
        test_rd0;
        test_back_to_back;
        test_halt;
        test_random;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/wb_commit_stage.md
WB_COMMIT_STAGE -- requirements
Module: wb_commit_stage

Interface
REQ-001 clk  in  1  clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 i_valid  in  1  MEM stage holds a valid instruction.
REQ-004 o_ready  out  1  stage can accept an instruction this cycle.
REQ-005 i_pc  in  64  PC of the incoming instruction.
REQ-006 i_inst  in  32  raw instruction word.
REQ-007 i_rd  in  5  destination register index.
REQ-008 i_rd_wen  in  1  instruction writes rd.
REQ-009 i_alu_res  in  64  non-load result: ALU, CSR read value or link address.
REQ-010 i_mem_addr  in  64  effective address for loads and stores.
REQ-011 i_mem_rdata  in  64  aligned doubleword read at i_mem_addr[63:3].
REQ-012 o_rd, o_rd_wen, o_rd_wdata  out  5/1/64  regfile write port, also fed to the commit unit.
REQ-013 o_pc, o_inst  out  64/32  committed PC and instruction.
REQ-014 o_cmtvalid  out  1  one-cycle commit strobe.
REQ-015 o_skipcmt  out  1  difftest skip for the committed instruction.
REQ-016 o_instret  out  64  count of committed instructions.
REQ-017 o_halted  out  1  halt instruction has committed.

Function
REQ-018 Accept when i_valid && o_ready; o_ready = (state == RUN).
REQ-019 FSM has states RUN and HALTED. An accepted instruction with i_inst[6:0]==7'h6b moves RUN to HALTED on the next cycle. HALTED exits only by reset. o_halted = (state == HALTED).
REQ-020 On accept, the cycle after the accept edge:
  - o_cmtvalid=1.
  - o_pc and o_inst are the registered i_pc and i_inst.
  - o_rd=i_rd.
  - o_rd_wen = i_rd_wen && (i_rd != 0).
REQ-021 Cycles with no accept: o_cmtvalid=0 and o_rd_wen=0. o_pc, o_inst, o_rd and o_rd_wdata hold their last values.
REQ-022 Latency is exactly one cycle from accept to commit outputs. Back-to-back accepts give consecutive commit strobes.
REQ-023 Load (opcode 7'h03): o_rd_wdata is extracted from i_mem_rdata.
  - Byte offset is i_mem_addr[2:0]; width and sign come from funct3 = i_inst[14:12].
  - funct3 0/1/2/3 = LB/LH/LW/LD, sign-extended.
  - funct3 4/5/6 = LBU/LHU/LWU, zero-extended.
  - funct3 7: o_rd_wdata=0.
  - Misaligned offsets use the low bits as given; no exception is raised.
REQ-024 Non-load: o_rd_wdata = i_alu_res.
REQ-025 o_skipcmt=1 when the committed instruction is either:
  - a load or store (opcode 7'h03 or 7'h23) with i_mem_addr[31]==0 (MMIO); or
  - opcode 7'h73 with funct3!=0 and i_inst[31:20] equal to 12'hB00 (mcycle) or 12'hC00 (cycle).
  Otherwise o_skipcmt=0. It is valid only while o_cmtvalid=1 and is 0 otherwise.
REQ-026 o_instret increments by 1 in the cycle o_cmtvalid=1 is presented, so it includes that commit. It wraps modulo 2^64.
REQ-027 The halt instruction commits normally: cmtvalid=1, counted in instret, rd write per REQ-020.
REQ-028 i_valid asserted while HALTED is ignored; no commit and no counter change.

Reset
REQ-029 rst has priority over accept. Reset sets:
  - state to RUN;
  - all outputs and registers to 0: o_rd, o_rd_wen, o_rd_wdata, o_pc, o_inst, o_cmtvalid, o_skipcmt, o_instret, o_halted.
  o_ready is 1 from the first cycle after reset.
REQ-030 Reset asserted mid-stream discards any instruction presented in that cycle. No commit strobe is produced for it.

Verification
REQ-031 Reset, then i_valid=1 with ADDI (rd=5, i_alu_res=0x2A) -> next cycle: o_cmtvalid=1, o_rd=5, o_rd_wen=1, o_rd_wdata=0x2A, o_instret=1.
REQ-032 LB with i_mem_addr=0x80000003 and i_mem_rdata=0x00000000_80000000 -> o_rd_wdata=0xFFFFFFFF_FFFFFF80, o_skipcmt=0. The same access as LBU gives 0x80.
REQ-033 SW with i_mem_addr=0x02004000 -> o_skipcmt=1. CSRRS rd=3 with csr 0xB00 -> o_skipcmt=1. CSRRS with csr 0x300 -> o_skipcmt=0.
REQ-034 Instruction with rd=0 and i_rd_wen=1 -> o_rd_wen=0, o_cmtvalid=1.
REQ-035 Halt inst 0x0000006b accepted:
  - next cycle: o_cmtvalid=1, o_halted=1, o_ready=0;
  - further i_valid pulses produce no commits and o_instret stays constant;
  - rst -> o_halted=0, o_ready=1.
REQ-036 Three back-to-back accepts, then an idle cycle, then rst asserted together with i_valid -> three consecutive strobes with o_instret=3. The cycle after rst shows o_cmtvalid=0 and o_instret=0.
